// File: rtl/bcd_pkg.sv
// Shared constants, types and helpers for the serial BCD accumulator and its display decoders.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SUM_W   = DIGIT_W + 1;
  localparam int unsigned SEG_W   = 7;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_ADJ = 4'd6;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic   carry;
    digit_t sum;
  } digit_res_t;

  function automatic logic digit_invalid(input digit_t d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_accumulator_if.sv
// Operand/result bus between the switch front end and the serial BCD accumulator.
interface bcd_serial_accumulator_if
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
);

  localparam int unsigned BUS_W = DIGIT_W * DIGITS;
  localparam int unsigned HEX_W = SEG_W * (DIGITS + 1);

  logic             start;
  logic             sub;
  logic             ci;
  logic [BUS_W-1:0] a;
  logic [BUS_W-1:0] b;
  logic             busy;
  logic             done;
  logic [BUS_W-1:0] s;
  logic             co;
  logic             err;
  logic [HEX_W-1:0] hex;

  modport master (
    output start, sub, ci, a, b,
    input  busy, done, s, co, err, hex
  );

  modport slave (
    input  start, sub, ci, a, b,
    output busy, done, s, co, err, hex
  );

endinterface

// File: rtl/bcd_seg7.sv
// BCD digit to active-low 7-segment decoder; non-decimal codes are blanked.
module bcd_seg7
  import bcd_pkg::*;
(
  input  digit_t           digit_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (digit_i <= BCD_MAX) begin
      seg_o = SEG_DIGIT[digit_i];
    end
  end

endmodule

// File: rtl/bcd_serial_accumulator.sv
// N-digit BCD add/subtract, one digit per clock LSD first, with decimal carry held between cycles
// and a start/busy/done handshake; drives one 7-segment display per result digit plus carry.
module bcd_serial_accumulator
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_serial_accumulator_if.slave bus
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_e           state_q, state_d;
  logic             accept_c, last_c, busy_d, done_d;
  logic             busy_q, done_q, sub_q, carry_q, co_q, err_q;
  logic [IDX_W-1:0] idx_q;
  digit_t           a_q [DIGITS];
  digit_t           b_q [DIGITS];
  digit_t           s_q [DIGITS];
  digit_t           in_a [DIGITS];
  digit_t           in_b [DIGITS];
  logic             in_err;
  digit_t           a_dig, b_dig;
  logic [SUM_W-1:0] t;
  digit_res_t       res;

  for (genvar i = 0; i < DIGITS; i++) begin : g_unpack
    assign in_a[i] = bus.a[i*DIGIT_W +: DIGIT_W];
    assign in_b[i] = bus.b[i*DIGIT_W +: DIGIT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start)          state_d = ST_ADD;
      ST_ADD:  if (idx_q == IDX_LAST)  state_d = ST_DONE;
      ST_DONE:                         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with the state register
  always_comb begin
    accept_c = (state_q == ST_IDLE) && bus.start;
    last_c   = (state_q == ST_ADD) && (idx_q == IDX_LAST);
    busy_d   = (state_d == ST_ADD);
    done_d   = (state_d == ST_DONE);
  end

  // Digit adder: 9's complement of B for subtract, +6 decimal adjust above nine
  always_comb begin
    a_dig     = a_q[idx_q];
    b_dig     = sub_q ? (BCD_MAX - b_q[idx_q]) : b_q[idx_q];
    t         = SUM_W'(a_dig) + SUM_W'(b_dig) + SUM_W'(carry_q);
    res.carry = 1'b0;
    res.sum   = t[DIGIT_W-1:0];
    if (t > SUM_W'(BCD_MAX)) begin
      res.carry = 1'b1;
      res.sum   = DIGIT_W'(t + SUM_W'(BCD_ADJ));
    end
  end

  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_invalid(in_a[i]) || digit_invalid(in_b[i])) begin
        in_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      s_q     <= '{default: '0};
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (accept_c) begin
        a_q     <= in_a;
        b_q     <= in_b;
        sub_q   <= bus.sub;
        carry_q <= bus.sub ? ~bus.ci : bus.ci;
        err_q   <= in_err;
        s_q     <= '{default: '0};
        co_q    <= 1'b0;
        idx_q   <= '0;
      end else if (state_q == ST_ADD) begin
        s_q[idx_q] <= res.sum;
        carry_q    <= res.carry;
        idx_q      <= last_c ? '0 : idx_q + IDX_W'(1);
        if (last_c) begin
          co_q <= res.carry;
        end
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.co   = co_q;
  assign bus.err  = err_q;

  logic [SEG_W*(DIGITS+1)-1:0] hex_c;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign bus.s[i*DIGIT_W +: DIGIT_W] = s_q[i];
    bcd_seg7 u_seg (
      .digit_i (s_q[i]),
      .seg_o   (hex_c[i*SEG_W +: SEG_W])
    );
  end

  bcd_seg7 u_seg_co (
    .digit_i ({{(DIGIT_W-1){1'b0}}, co_q}),
    .seg_o   (hex_c[DIGITS*SEG_W +: SEG_W])
  );

  assign bus.hex = hex_c;

endmodule

// File: tb/tb_bcd_serial_accumulator.sv
// Self-checking bench for bcd_serial_accumulator (DIGITS=4) using an expected-result queue.
module tb_bcd_serial_accumulator;

  localparam int unsigned N = 4;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t sb_q [$];

  bcd_serial_accumulator_if #(.DIGITS(N)) bus ();

  bcd_serial_accumulator #(.DIGITS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [15:0] x);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int          w;
    w = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(w % 10);
      w = w / 10;
    end
    return r;
  endfunction

  // Decimal reference for valid operands
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic ci,
                       output logic [15:0] s, output logic co);
    int r;
    if (!sub) begin
      r  = bcd2int(a) + bcd2int(b) + int'(ci);
      co = (r >= 10000);
      r  = r % 10000;
    end else begin
      r  = bcd2int(a) - bcd2int(b) - int'(ci);
      co = (r >= 0);
      if (r < 0) r = r + 10000;
    end
    s = int2bcd(r);
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [34:0] hex_ref(input logic [15:0] s, input logic co);
    logic [34:0] h;
    for (int i = 0; i < 4; i++) h[7*i +: 7] = seg_ref(s[4*i +: 4]);
    h[34:28] = seg_ref({3'b000, co});
    return h;
  endfunction

  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic ci, input logic [15:0] es,
                        input logic eco, input logic eerr, input bit scramble);
    exp_t e;
    int   lat;
    int   busy_cnt;
    bit   seen;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sub = sub; bus.ci = ci; bus.start = 1'b1;
    e.s = es; e.co = eco; e.err = eerr;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; busy_cnt = 0; seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      if (bus.busy) busy_cnt++;
      if (scramble && c == 2) begin
        bus.a = ~a; bus.b = ~b; bus.sub = ~sub; bus.ci = ~ci;
      end
      if (bus.done) begin
        seen = 1'b1;
        lat  = c;
      end else begin
        @(posedge clk); #1;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s.timeout: done not seen within 20 cycles", name);
      void'(sb_q.pop_front());
      return;
    end
    e = sb_q.pop_front();
    vectors++;
    if (lat !== 5) begin
      miscompares++;
      $display("FAIL %s.latency: got %0d expected 5", name, lat);
    end
    vectors++;
    if (busy_cnt !== 4) begin
      miscompares++;
      $display("FAIL %s.busy_cycles: got %0d expected 4", name, busy_cnt);
    end
    vectors++;
    if (bus.s !== e.s) begin
      miscompares++;
      $display("FAIL %s.s: got %h expected %h", name, bus.s, e.s);
    end
    vectors++;
    if (bus.co !== e.co) begin
      miscompares++;
      $display("FAIL %s.co: got %b expected %b", name, bus.co, e.co);
    end
    vectors++;
    if (bus.err !== e.err) begin
      miscompares++;
      $display("FAIL %s.err: got %b expected %b", name, bus.err, e.err);
    end
    vectors++;
    if (bus.hex !== hex_ref(e.s, e.co)) begin
      miscompares++;
      $display("FAIL %s.hex: got %h expected %h", name, bus.hex, hex_ref(e.s, e.co));
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s.done_pulse: got done=%b busy=%b expected 0 0", name, bus.done, bus.busy);
    end
  endtask

  task automatic run_model(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input logic ci, input bit scramble);
    logic [15:0] es;
    logic        eco;
    model(a, b, sub, ci, es, eco);
    run_op(name, a, b, sub, ci, es, eco, 1'b0, scramble);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.ci = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.s !== 16'h0000 ||
        bus.co !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset.regs: got busy=%b done=%b s=%h co=%b err=%b expected all 0",
               bus.busy, bus.done, bus.s, bus.co, bus.err);
    end
    vectors++;
    if (bus.hex !== {5{7'b1000000}}) begin
      miscompares++;
      $display("FAIL reset.hex: got %h expected %h", bus.hex, {5{7'b1000000}});
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_model("add", 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
    run_op("add_const", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0);
    run_model("add_ci", 16'h0999, 16'h0001, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    run_op("wrap", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_subtract();
    run_op("sub_noborrow", 16'h0500, 16'h0123, 1'b1, 1'b0, 16'h0377, 1'b1, 1'b0, 1'b0);
    run_op("sub_borrow", 16'h0123, 16'h0500, 1'b1, 1'b0, 16'h9623, 1'b0, 1'b0, 1'b0);
    run_model("sub_bin", 16'h1000, 16'h0001, 1'b1, 1'b1, 1'b0);
    run_model("sub_equal", 16'h4321, 16'h4321, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_invalid();
    run_op("invalid", 16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 1'b0);
    run_model("invalid_clear", 16'h0042, 16'h0007, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h5678; bus.sub = 1'b0; bus.ci = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.s !== 16'h0000 || bus.co !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid.regs: got busy=%b done=%b s=%h co=%b expected 0 0 0000 0",
               bus.busy, bus.done, bus.s, bus.co);
    end
    vectors++;
    if (bus.hex !== {5{7'b1000000}}) begin
      miscompares++;
      $display("FAIL reset_mid.hex: got %h expected %h", bus.hex, {5{7'b1000000}});
    end
    rst = 1'b0;
    run_model("after_reset", 16'h2468, 16'h1357, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_scramble();
    run_op("scramble", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] es;
    logic        eco;
    exp_t        e;
    int          last;
    int          n;
    model(16'h4321, 16'h1111, 1'b0, 1'b1, es, eco);
    @(negedge clk);
    bus.a = 16'h4321; bus.b = 16'h1111; bus.sub = 1'b0; bus.ci = 1'b1; bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.s = es; e.co = eco; e.err = 1'b0;
      sb_q.push_back(e);
    end
    last = -1; n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        e = sb_q.pop_front();
        vectors++;
        if (bus.s !== e.s || bus.co !== e.co) begin
          miscompares++;
          $display("FAIL b2b.result%0d: got s=%h co=%b expected s=%h co=%b", n, bus.s, bus.co, e.s, e.co);
        end
        if (last >= 0) begin
          vectors++;
          if (c - last !== 6) begin
            miscompares++;
            $display("FAIL b2b.period%0d: got %0d expected 6", n, c - last);
          end
        end
        last = c;
        n++;
        if (n == 3) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    vectors++;
    if (n !== 3) begin
      miscompares++;
      $display("FAIL b2b.count: got %0d done pulses expected 3", n);
    end
    sb_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b.idle: got busy=%b expected 0", bus.busy);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_add();
    test_wrap();
    test_subtract();
    test_invalid();
    test_reset_mid_op();
    test_scramble();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
